cla_seq_adder: RTL and testbench

Sequential wide adder that sits directly downstream of the team's 4-bit carry-lookahead nibble adder datapath. It latches two wide operands on a start handshake, pushes them through a 4-bit lookahead slice one nibble per clock (LSB nibble first), carries the nibble carry-out forward in a register, and presents the assembled sum and final carry with a one-cycle done pulse. It trades latency for area in wide additions where a full-width lookahead tree is not justified.

---
 rtl/cla_seq_adder.sv | 180 ++++++++++++++++++
 tb/tb_cla_seq_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// cla_seq_adder
// Sequential wide adder: operands are latched on an accepted start, then
// summed one 4-bit lookahead slice per clock, least significant nibble first.
// The slice carry-out is held in a register and fed into the next nibble.
//
// Optional feature macro: CLA_SEQ_SUB_EN adds the i_sub port (subtract mode).
//
// Ports
//   i_clk    clock, all state changes on the rising edge
//   i_rst    synchronous active-high reset
//   i_start  begin an operation (accepted only while o_busy=0)
//   i_a/i_b  operands, sampled on the accepting edge
//   i_sub    (CLA_SEQ_SUB_EN only) 1 = compute a-b, sampled with operands
//   o_busy   high while nibbles are being processed
//   o_done   one-cycle pulse when o_sum/o_cout are final
//   o_sum    result, valid from the done pulse until the next accepted start
//   o_cout   carry out of the top nibble (no-borrow flag when subtracting)
module cla_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [4*NIBBLES-1:0]   i_a,
  input  logic [4*NIBBLES-1:0]   i_b,
`ifdef CLA_SEQ_SUB_EN
  input  logic                   i_sub,
`endif
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4*NIBBLES-1:0]   o_sum,
  output logic                   o_cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_carry;
  logic             r_done;
  logic [IDX_W-1:0] r_idx;

  logic [3:0]       w_a_nib_arr [NIBBLES];
  logic [3:0]       w_b_nib_arr [NIBBLES];
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_s;

  logic [W-1:0]     w_b_load;
  logic             w_cin_load;

`ifdef CLA_SEQ_SUB_EN
  // Two's-complement subtract: invert B once at load, seed carry with 1.
  assign w_b_load   = i_sub ? ~i_b : i_b;
  assign w_cin_load = i_sub;
`else
  assign w_b_load   = i_b;
  assign w_cin_load = 1'b0;
`endif

  // Split latched operands into nibble lanes.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign w_a_nib_arr[gi] = r_a[4*gi +: 4];
      assign w_b_nib_arr[gi] = r_b[4*gi +: 4];
    end
  endgenerate

  // Select the nibble currently being processed.
  always_comb begin
    w_a_nib = 4'd0;
    w_b_nib = 4'd0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_nib = w_a_nib_arr[k];
        w_b_nib = w_b_nib_arr[k];
      end
    end
  end

  // 4-bit lookahead slice with carry-in, carries in expanded lookahead form.
  assign w_g    = w_a_nib & w_b_nib;
  assign w_p    = w_a_nib ^ w_b_nib;
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_s    = w_p ^ w_c[3:0];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= w_b_load;
        r_sum   <= '0;
        r_cout  <= 1'b0;
        r_carry <= w_cin_load;
        r_idx   <= '0;
      end else if (r_state == S_RUN) begin
        for (int k = 0; k < NIBBLES; k++) begin
          if (r_idx == IDX_W'(k)) begin
            r_sum[4*k +: 4] <= w_s;
          end
        end
        r_carry <= w_c[4];
        r_idx   <= r_idx + 1'b1;
        if (w_last) begin
          r_cout <= w_c[4];
          r_done <= 1'b1;
          r_idx  <= '0;
        end
      end
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed testbench for cla_seq_adder: a 4-nibble instance exercises
// latency, carry ripple, start-while-busy, back-to-back and reset; a
// 1-nibble instance covers the degenerate single-slice case.
module tb_cla_seq_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  logic        start1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        busy1;
  logic        done1;
  logic [3:0]  sum1;
  logic        cout1;

  int n_vec;
  int n_bad;

  cla_seq_adder #(.NIBBLES(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
`ifdef CLA_SEQ_SUB_EN
    .i_sub   (sub),
`endif
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout)
  );

  cla_seq_adder #(.NIBBLES(1)) dut1 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start1),
    .i_a     (a1),
    .i_b     (b1),
`ifdef CLA_SEQ_SUB_EN
    .i_sub   (1'b0),
`endif
    .o_busy  (busy1),
    .o_done  (done1),
    .o_sum   (sum1),
    .o_cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled and inputs driven 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0; sub = 1'b0;
    a = '0; b = '0; a1 = '0; b1 = '0;
    tick(); tick();
    n_vec++;
    if ({busy, done, sum, cout} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset4: busy=%b done=%b sum=%h cout=%b, need all 0", busy, done, sum, cout);
    end
    n_vec++;
    if ({busy1, done1, sum1, cout1} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset1: busy=%b done=%b sum=%h cout=%b, need all 0", busy1, done1, sum1, cout1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0F0F};
    logic [15:0] vb [5] = '{16'h4321, 16'h0001, 16'h8000, 16'hFFFF, 16'h0101};
    logic [15:0] vs [5] = '{16'h5555, 16'h0000, 16'h0000, 16'hFFFE, 16'h1010};
    logic        vc [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      a = va[i]; b = vb[i]; start = 1'b1;
      tick();
      start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL add%0d_busy_c%0d: busy=%b done=%b, need busy=1 done=0", i, k, busy, done);
        end
        tick();
      end
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b1) begin
        n_bad++;
        $display("FAIL add%0d_done: busy=%b done=%b, need busy=0 done=1", i, busy, done);
      end
      n_vec++;
      if (sum !== vs[i] || cout !== vc[i]) begin
        n_bad++;
        $display("FAIL add%0d_result: sum=%h cout=%b, need sum=%h cout=%b", i, sum, cout, vs[i], vc[i]);
      end
      $display("add a=%h b=%h -> sum=%h cout=%b", va[i], vb[i], sum, cout);
      tick();
      n_vec++;
      if (done !== 1'b0 || sum !== vs[i]) begin
        n_bad++;
        $display("FAIL add%0d_hold: done=%b sum=%h, need done=0 sum=%h", i, done, sum, vs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    a = 16'h00F0; b = 16'h0010; start = 1'b1;
    tick();
    a = 16'hAAAA; b = 16'hAAAA;          // start stays high while busy
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_busy_c%0d: busy=%b done=%b, need busy=1 done=0", k, busy, done);
      end
    end
    tick();
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 16'h0100 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first: done=%b busy=%b sum=%h cout=%b, need 1 0 0100 0", done, busy, sum, cout);
    end
    $display("add a=00f0 b=0010 (start held busy) -> sum=%h cout=%b", sum, cout);
    a = 16'h0001; b = 16'h0002;          // start still high in the done cycle
    tick();
    start = 1'b0;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: done=%b busy=%b, need done=0 busy=1", done, busy);
    end
    tick(); tick(); tick(); tick();
    n_vec++;
    if (done !== 1'b1 || sum !== 16'h0003 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: done=%b sum=%h cout=%b, need 1 0003 0", done, sum, cout);
    end
    $display("add a=0001 b=0002 (back-to-back) -> sum=%h cout=%b", sum, cout);
    tick();
  endtask

  task automatic test_reset_mid();
    int seen_done;
    a = 16'h1234; b = 16'h4321; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({busy, done, sum, cout} !== 19'd0) begin
      n_bad++;
      $display("FAIL rst_mid: busy=%b done=%b sum=%h cout=%b, need all 0", busy, done, sum, cout);
    end
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done++;
      tick();
    end
    n_vec++;
    if (seen_done !== 0) begin
      n_bad++;
      $display("FAIL rst_mid_quiet: %0d active cycles after reset, need 0", seen_done);
    end
    // reset coincident with start: start is ignored
    a = 16'h1111; b = 16'h1111; start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || sum !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_start: busy=%b sum=%h, need busy=0 sum=0000", busy, sum);
    end
    $display("reset mid-run and with start -> busy=%b done=%b sum=%h", busy, done, sum);
    tick();
  endtask

  task automatic test_sub();
`ifdef CLA_SEQ_SUB_EN
    logic [15:0] va [2] = '{16'h0005, 16'h0007};
    logic [15:0] vb [2] = '{16'h0007, 16'h0005};
    logic [15:0] vs [2] = '{16'hFFFE, 16'h0002};
    logic        vc [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      a = va[i]; b = vb[i]; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; sub = 1'b0;
      tick(); tick(); tick(); tick();
      n_vec++;
      if (done !== 1'b1 || sum !== vs[i] || cout !== vc[i]) begin
        n_bad++;
        $display("FAIL sub%0d: done=%b sum=%h cout=%b, need 1 %h %b", i, done, sum, cout, vs[i], vc[i]);
      end
      $display("sub a=%h b=%h -> sum=%h cout=%b", va[i], vb[i], sum, cout);
      tick();
    end
`endif
  endtask

  task automatic test_one_nibble();
    a1 = 4'h9; b1 = 4'h8; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_vec++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      n_bad++;
      $display("FAIL nib1_busy: busy=%b done=%b, need busy=1 done=0", busy1, done1);
    end
    tick();
    n_vec++;
    if (busy1 !== 1'b0 || done1 !== 1'b1 || sum1 !== 4'h1 || cout1 !== 1'b1) begin
      n_bad++;
      $display("FAIL nib1_done: busy=%b done=%b sum=%h cout=%b, need 0 1 1 1", busy1, done1, sum1, cout1);
    end
    $display("nib1 a=9 b=8 -> sum=%h cout=%b", sum1, cout1);
    tick();
    n_vec++;
    if (done1 !== 1'b0) begin
      n_bad++;
      $display("FAIL nib1_pulse: done=%b, need 0", done1);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_reset_mid();
    test_sub();
    test_one_nibble();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
